ad9361_rx_deframer: RTL and testbench

Parametrised receive deframer for the AD9361 LVDS data path. Takes per-edge lane data and frame bits from the IDDR stage, checks frame alignment with a lock state machine, and reassembles sign-extended I/Q words for one or two channels. Only channel 0 is produced in 1R1T mode, and both channels in 2R2T mode. Sits between the IO primitives (IBUFDS/IDELAY/IDDR) and the DSP chain in the `data_clk` domain.

---
 rtl/ad9361_rx_deframer.sv | 171 +++++++++++++++++
 tb/tb_ad9361_rx_deframer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad9361_rx_deframer.sv
// AD9361 LVDS receive deframer: frame-lock state machine and I/Q word reassembly.
// Optional AD9361_RX_ERRCNT_EN builds the saturating frame error counter.
module ad9361_rx_deframer #(
    parameter int LANE_W    = 6,
    parameter int OUT_W     = 16,
    parameter int MAX_CH    = 2,
    parameter int LOCK_CNT  = 8,
    parameter int ERR_CNT_W = 16
) (
    input  logic                    i_data_clk,
    input  logic                    i_rst,
    input  logic [LANE_W-1:0]       i_din_rise,
    input  logic [LANE_W-1:0]       i_din_fall,
    input  logic                    i_frame_rise,
    input  logic                    i_frame_fall,
    input  logic                    i_chan_mode,
    input  logic                    i_swap_iq,
    output logic [MAX_CH*OUT_W-1:0] o_data_i,
    output logic [MAX_CH*OUT_W-1:0] o_data_q,
    output logic [MAX_CH-1:0]       o_data_valid,
    output logic                    o_locked,
    output logic                    o_frame_err,
    output logic [ERR_CNT_W-1:0]    o_err_cnt
);
    localparam int SAMPLE_W = 2 * LANE_W;

    typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_LOCKED} state_t;

    state_t                  r_state;
    logic [1:0]              r_ph;
    logic [7:0]              r_good;
    logic [1:0]              r_prev_frame;
    logic                    r_mode;
    logic [SAMPLE_W-1:0]     r_prev_word;
    logic [MAX_CH*OUT_W-1:0] r_data_i;
    logic [MAX_CH*OUT_W-1:0] r_data_q;
    logic [MAX_CH-1:0]       r_valid;
    logic                    r_locked;
    logic                    r_frame_err;

    logic                w_mode1r;
    logic                w_mode_chg;
    logic [1:0]          w_frame;
    logic [SAMPLE_W-1:0] w_word;
    logic [1:0]          w_last_ph;
    logic                w_exp_hi;
    logic                w_match;
    logic                w_start;
    logic                w_viol;
    logic [OUT_W-1:0]    w_ext_prev;
    logic [OUT_W-1:0]    w_ext_cur;
    logic [OUT_W-1:0]    w_out_i;
    logic [OUT_W-1:0]    w_out_q;

    assign w_mode1r   = (MAX_CH == 1) ? 1'b1 : i_chan_mode;
    assign w_mode_chg = w_mode1r != r_mode;
    assign w_frame    = {i_frame_rise, i_frame_fall};
    assign w_word     = {i_din_rise, i_din_fall};
    assign w_last_ph  = w_mode1r ? 2'd1 : 2'd3;
    assign w_exp_hi   = w_mode1r ? (r_ph == 2'd0) : (r_ph < 2'd2);
    // Rise/fall disagreement never equals 11 or 00, so it falls out as a mismatch.
    assign w_match    = w_frame == {2{w_exp_hi}};
    assign w_start    = (w_frame == 2'b11) && (r_prev_frame == 2'b00);
    assign w_viol     = (r_state == S_LOCKED) && !w_mode_chg && !w_match;

    assign w_ext_prev = OUT_W'($signed(r_prev_word));
    assign w_ext_cur  = OUT_W'($signed(w_word));
    assign w_out_i    = i_swap_iq ? w_ext_cur  : w_ext_prev;
    assign w_out_q    = i_swap_iq ? w_ext_prev : w_ext_cur;

    always_ff @(posedge i_data_clk) begin
        if (i_rst) begin
            r_state      <= S_SEARCH;
            r_ph         <= '0;
            r_good       <= '0;
            r_prev_frame <= w_frame;
            r_mode       <= w_mode1r;
            r_prev_word  <= '0;
            r_data_i     <= '0;
            r_data_q     <= '0;
            r_valid      <= '0;
            r_locked     <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_prev_frame <= w_frame;
            r_mode       <= w_mode1r;
            r_prev_word  <= w_word;
            r_valid      <= '0;
            r_frame_err  <= w_viol;
            if (w_mode_chg) begin
                r_state  <= S_SEARCH;
                r_ph     <= '0;
                r_good   <= '0;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    S_SEARCH: begin
                        if (w_start) begin
                            // The transition cycle itself is phase 0 of the first period.
                            r_state <= S_TRACK;
                            r_good  <= '0;
                            r_ph    <= 2'd1;
                        end
                    end
                    S_TRACK: begin
                        if (!w_match) begin
                            r_state <= S_SEARCH;
                            r_good  <= '0;
                            r_ph    <= '0;
                        end else if (r_ph == w_last_ph) begin
                            r_ph <= '0;
                            if (r_good == 8'(LOCK_CNT - 1)) begin
                                r_state  <= S_LOCKED;
                                r_locked <= 1'b1;
                                r_good   <= '0;
                            end else begin
                                r_good <= r_good + 8'd1;
                            end
                        end else begin
                            r_ph <= r_ph + 2'd1;
                        end
                    end
                    S_LOCKED: begin
                        if (!w_match) begin
                            r_state  <= S_SEARCH;
                            r_locked <= 1'b0;
                            r_good   <= '0;
                            r_ph     <= '0;
                        end else begin
                            for (int c = 0; c < MAX_CH; c++) begin
                                if (r_ph == 2'(2 * c + 1)) begin
                                    r_data_i[c*OUT_W +: OUT_W] <= w_out_i;
                                    r_data_q[c*OUT_W +: OUT_W] <= w_out_q;
                                    r_valid[c]                 <= 1'b1;
                                end
                            end
                            r_ph <= (r_ph == w_last_ph) ? 2'd0 : r_ph + 2'd1;
                        end
                    end
                    default: begin
                        r_state <= S_SEARCH;
                        r_ph    <= '0;
                        r_good  <= '0;
                    end
                endcase
            end
        end
    end

`ifdef AD9361_RX_ERRCNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge i_data_clk) begin
        if (i_rst)
            r_err_cnt <= '0;
        else if (w_viol && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + 1'b1;
    end

    assign o_err_cnt = r_err_cnt;
`else
    assign o_err_cnt = '0;
`endif

    assign o_data_i     = r_data_i;
    assign o_data_q     = r_data_q;
    assign o_data_valid = r_valid;
    assign o_locked     = r_locked;
    assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_ad9361_rx_deframer.sv
// Randomized bench for ad9361_rx_deframer with a cycle-indexed behavioural model.
// Two DUTs share stimulus: default widths and a 2-bit error counter.
module tb_ad9361_rx_deframer;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [5:0]  i_din_rise = '0, i_din_fall = '0;
    logic        i_frame_rise = 1'b0, i_frame_fall = 1'b0;
    logic        i_chan_mode = 1'b0, i_swap_iq = 1'b0;

    logic [31:0] o1_di, o1_dq, o2_di, o2_dq;
    logic [1:0]  o1_vld, o2_vld;
    logic        o1_lock, o2_lock, o1_ferr, o2_ferr;
    logic [15:0] o1_err;
    logic [1:0]  o2_err;

    always #5 clk = ~clk;

    ad9361_rx_deframer dut1 (
        .i_data_clk(clk), .i_rst(i_rst), .i_din_rise(i_din_rise), .i_din_fall(i_din_fall),
        .i_frame_rise(i_frame_rise), .i_frame_fall(i_frame_fall), .i_chan_mode(i_chan_mode),
        .i_swap_iq(i_swap_iq), .o_data_i(o1_di), .o_data_q(o1_dq), .o_data_valid(o1_vld),
        .o_locked(o1_lock), .o_frame_err(o1_ferr), .o_err_cnt(o1_err));

    ad9361_rx_deframer #(.ERR_CNT_W(2)) dut2 (
        .i_data_clk(clk), .i_rst(i_rst), .i_din_rise(i_din_rise), .i_din_fall(i_din_fall),
        .i_frame_rise(i_frame_rise), .i_frame_fall(i_frame_fall), .i_chan_mode(i_chan_mode),
        .i_swap_iq(i_swap_iq), .o_data_i(o2_di), .o_data_q(o2_dq), .o_data_valid(o2_vld),
        .o_locked(o2_lock), .o_frame_err(o2_ferr), .o_err_cnt(o2_err));

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: phase = (cycle - anchor) mod P, anchor is the cycle of the 00->11 edge.
    bit          m_live = 0;
    int          tc = 0, anchor = -1, good = 0, errs = 0;
    bit          m_locked = 0, m_ferr = 0, pmode = 0;
    logic [1:0]  prevf = 2'b00, m_vld = '0;
    logic [11:0] prevw = '0;
    logic [15:0] m_di [2], m_dq [2];

    function automatic logic [15:0] sx(input logic [11:0] w);
        return (w >= 12'h800) ? 16'(w) + 16'hF000 : 16'(w);
    endfunction

    function automatic int exp_err(input int w);
`ifdef AD9361_RX_ERRCNT_EN
        int mx = (1 << w) - 1;
        return (errs > mx) ? mx : errs;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk) begin
        logic [1:0]  f;
        logic [11:0] w;
        bit          m;
        int          p, ph, c;
        f = {i_frame_rise, i_frame_fall};
        w = {i_din_rise, i_din_fall};
        m = i_chan_mode;
        p = m ? 2 : 4;
        m_ferr = 0;
        m_vld  = '0;
        if (i_rst) begin
            anchor = -1; good = 0; errs = 0; m_locked = 0; m_live = 1;
            for (int k = 0; k < 2; k++) begin m_di[k] = '0; m_dq[k] = '0; end
        end else if (m != pmode) begin
            m_locked = 0; anchor = -1; good = 0;
        end else if (anchor < 0) begin
            if (f == 2'b11 && prevf == 2'b00) begin anchor = tc; good = 0; end
        end else begin
            ph = (tc - anchor) % p;
            if (f != ((ph < p / 2) ? 2'b11 : 2'b00)) begin
                if (m_locked) begin m_ferr = 1; errs++; m_locked = 0; end
                anchor = -1; good = 0;
            end else if (m_locked) begin
                if (ph % 2 == 1) begin
                    c = ph / 2;
                    m_di[c] = i_swap_iq ? sx(w) : sx(prevw);
                    m_dq[c] = i_swap_iq ? sx(prevw) : sx(w);
                    m_vld[c] = 1'b1;
                end
            end else if (ph == p - 1) begin
                good++;
                if (good == 8) m_locked = 1;
            end
        end
        prevf = f; pmode = m; prevw = w; tc++;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("d1_data_i", 64'(o1_di), 64'({m_di[1], m_di[0]}));
            chk("d1_data_q", 64'(o1_dq), 64'({m_dq[1], m_dq[0]}));
            chk("d1_valid",  64'(o1_vld), 64'(m_vld));
            chk("d1_locked", 64'(o1_lock), 64'(m_locked));
            chk("d1_ferr",   64'(o1_ferr), 64'(m_ferr));
            chk("d1_errcnt", 64'(o1_err), 64'(exp_err(16)));
            chk("d2_data_i", 64'(o2_di), 64'({m_di[1], m_di[0]}));
            chk("d2_locked", 64'(o2_lock), 64'(m_locked));
            chk("d2_ferr",   64'(o2_ferr), 64'(m_ferr));
            chk("d2_valid",  64'(o2_vld), 64'(m_vld));
            chk("d2_errcnt", 64'(o2_err), 64'(exp_err(2)));
        end
    end

    task automatic cyc(input logic [1:0] f, input logic [11:0] w);
        i_frame_rise = f[1]; i_frame_fall = f[0];
        i_din_rise = w[11:6]; i_din_fall = w[5:0];
        @(negedge clk);
    endtask

    function automatic logic [1:0] pat(input int ph, input int p);
        return (ph < p / 2) ? 2'b11 : 2'b00;
    endfunction

    task automatic periods(input int n, input int p);
        for (int k = 0; k < n; k++)
            for (int ph = 0; ph < p; ph++) cyc(pat(ph, p), 12'($urandom));
    endtask

    // Locked 2R2T: violate at phase 1 (frame 10), finish the period, then relock.
    task automatic violate_and_relock();
        cyc(2'b11, 12'($urandom));
        cyc(2'b10, 12'($urandom));
        cyc(2'b00, 12'($urandom));
        cyc(2'b00, 12'($urandom));
        periods(9, 4);
    endtask

    localparam logic [11:0] WD [4] = '{12'hA5F, 12'h123, 12'h800, 12'h7FF};
`ifdef AD9361_RX_ERRCNT_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    initial begin
        int gph, gp;
        repeat (2) @(negedge clk);
        chk("rst_locked", 64'(o1_lock), 64'd0);
        chk("rst_data_i", 64'(o1_di), 64'd0);
        i_rst = 1'b0;

        // 2R2T lock on fixed words
        cyc(2'b00, 12'h0); cyc(2'b00, 12'h0);
        for (int p = 0; p < 10; p++)
            for (int ph = 0; ph < 4; ph++) begin
                cyc(pat(ph, 4), WD[ph]);
                if (p == 7 && ph == 2) chk("lock_early", 64'(o1_lock), 64'd0);
                if (p == 7 && ph == 3) chk("lock_8th", 64'(o1_lock), 64'd1);
            end
        chk("ch_i_lit", 64'(o1_di), 64'h0000_0000_F800_FA5F);
        chk("ch_q_lit", 64'(o1_dq), 64'h0000_0000_07FF_0123);
        periods(5, 4);

        // single violation then relock
        cyc(2'b11, 12'($urandom));
        cyc(2'b10, 12'($urandom));
        chk("viol_ferr", 64'(o1_ferr), 64'd1);
        chk("viol_lock", 64'(o1_lock), 64'd0);
        chk("viol_err", 64'(o1_err), 64'(ERR_EN));
        cyc(2'b00, 12'($urandom));
        chk("viol_ferr_once", 64'(o1_ferr), 64'd0);
        cyc(2'b00, 12'($urandom));
        periods(9, 4);
        chk("relock", 64'(o1_lock), 64'd1);

        // five more violations: 2-bit counter saturates
        repeat (5) violate_and_relock();
        chk("sat_w2", 64'(o2_err), 64'(ERR_EN * 3));
        chk("cnt_w16", 64'(o1_err), 64'(ERR_EN * 6));

        // mode toggle to 1R1T while locked
        i_chan_mode = 1'b1;
        for (int p = 0; p < 15; p++)
            for (int ph = 0; ph < 2; ph++) begin
                if (p == 10) i_swap_iq = 1'b1;
                cyc(pat(ph, 2), ph == 0 ? 12'h001 : 12'hFFF);
                if (p == 0 && ph == 0) begin
                    chk("mode_unlock", 64'(o1_lock), 64'd0);
                    chk("mode_noerr", 64'(o1_ferr), 64'd0);
                end
            end
        chk("r1_lock", 64'(o1_lock), 64'd1);
        chk("r1_i", 64'(o1_di[15:0]), 64'h0000_0000_0000_FFFF);
        chk("r1_q", 64'(o1_dq[15:0]), 64'h0000_0000_0000_0001);

        // randomized stress: mode flips, swaps, corrupted frame bits
        gph = 0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(299) == 0) begin i_chan_mode = ~i_chan_mode; gph = 0; end
            if ($urandom_range(99) == 0) i_swap_iq = ~i_swap_iq;
            gp = i_chan_mode ? 2 : 4;
            if ($urandom_range(149) == 0) cyc(2'($urandom), 12'($urandom));
            else cyc(pat(gph, gp), 12'($urandom));
            gph = (gph + 1) % gp;
        end

        // reset during the 5th good period
        i_chan_mode = 1'b0; i_swap_iq = 1'b0;
        repeat (4) cyc(2'b00, 12'($urandom));
        periods(4, 4);
        cyc(2'b11, 12'($urandom)); cyc(2'b11, 12'($urandom));
        i_rst = 1'b1;
        cyc(2'b00, 12'($urandom));
        chk("mid_rst_outs", 64'({o1_di, o1_dq}), 64'd0);
        chk("mid_rst_flags", 64'({o1_vld, o1_lock, o1_ferr, o1_err}), 64'd0);
        i_rst = 1'b0;
        cyc(2'b00, 12'($urandom));
        for (int p = 0; p < 8; p++)
            for (int ph = 0; ph < 4; ph++) begin
                cyc(pat(ph, 4), 12'($urandom));
                if (p == 6 && ph == 3) chk("rst_nolock", 64'(o1_lock), 64'd0);
                if (p == 7 && ph == 3) chk("rst_relock", 64'(o1_lock), 64'd1);
            end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
